// File: rtl/edge_window_sequencer_if.sv
// Handshake bundle between the edge-window sequencer and its surroundings
// (host control, address counter, memory port, kernel).
interface edge_window_sequencer_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WIN_PIX = 9
);
    // host control
    logic                        i_start;
    logic                        i_stop;
    logic                        o_busy;
    logic                        o_frame_done;
    logic                        o_error;
    logic [31:0]                 o_pix_count;
    // address counter
    logic                        o_inc_raddr;
    logic                        i_r_ready;
    logic                        o_inc_waddr;
    logic                        i_w_ready;
    logic                        i_done;
    // memory port
    logic                        o_mem_rd;
    logic                        i_rd_valid;
    logic [DATA_W-1:0]           i_rd_data;
    logic                        o_mem_wr;
    logic                        i_wr_ack;
    logic [DATA_W-1:0]           o_wr_data;
    // kernel
    logic [WIN_PIX*DATA_W-1:0]   o_win_data;
    logic                        o_calc_start;
    logic                        i_calc_done;
    logic [DATA_W-1:0]           i_result;

    // sequencer side
    modport master (
        input  i_start, i_stop, i_r_ready, i_w_ready, i_done,
               i_rd_valid, i_rd_data, i_wr_ack, i_calc_done, i_result,
        output o_busy, o_frame_done, o_error, o_pix_count,
               o_inc_raddr, o_inc_waddr, o_mem_rd, o_mem_wr, o_wr_data,
               o_win_data, o_calc_start
    );

    // environment side
    modport slave (
        output i_start, i_stop, i_r_ready, i_w_ready, i_done,
               i_rd_valid, i_rd_data, i_wr_ack, i_calc_done, i_result,
        input  o_busy, o_frame_done, o_error, o_pix_count,
               o_inc_raddr, o_inc_waddr, o_mem_rd, o_mem_wr, o_wr_data,
               o_win_data, o_calc_start
    );
endinterface

// File: rtl/edge_window_sequencer.sv
// Per-pixel sequencer: gathers a 3x3 window one read address at a time,
// launches the kernel, then writes the result; repeats until the address
// counter flags the last output pixel. Every wait is bounded by TIMEOUT.
module edge_window_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned WIN_PIX = 9,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    n_rst,
    edge_window_sequencer_if.master bus
);
    localparam int unsigned IDX_W = (WIN_PIX > 1) ? $clog2(WIN_PIX) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ_R, S_WAIT_R, S_RD, S_CALC,
        S_REQ_W, S_WAIT_W, S_WR, S_DONE, S_ERR
    } state_t;

    state_t                           state;
    logic [IDX_W-1:0]                 idx;
    logic [CNT_W-1:0]                 wait_cnt;
    logic                             done_latch;
    logic [WIN_PIX-1:0][DATA_W-1:0]   win;
    logic [DATA_W-1:0]                wr_data;
    logic [31:0]                      pix_count;
    logic                             inc_raddr;
    logic                             inc_waddr;
    logic                             mem_rd;
    logic                             mem_wr;
    logic                             calc_start;
    logic                             busy;
    logic                             frame_done;
    logic                             error;

    logic                             waiting_c;
    logic                             hit_c;
    logic                             timeout_c;
    logic                             active_c;

    // Which states wait on a handshake, and whether it arrived this cycle
    always_comb begin
        waiting_c = 1'b0;
        hit_c     = 1'b0;
        case (state)
            S_WAIT_R: begin waiting_c = 1'b1; hit_c = bus.i_r_ready;   end
            S_RD:     begin waiting_c = 1'b1; hit_c = bus.i_rd_valid;  end
            S_CALC:   begin waiting_c = 1'b1; hit_c = bus.i_calc_done; end
            S_WAIT_W: begin waiting_c = 1'b1; hit_c = bus.i_w_ready;   end
            S_WR:     begin waiting_c = 1'b1; hit_c = bus.i_wr_ack;    end
            default:  ;
        endcase
    end

    assign timeout_c = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign active_c  = !(state inside {S_IDLE, S_DONE, S_ERR});

    // Sequencer FSM with registered outputs; abort beats timeout beats handshakes
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            wait_cnt   <= '0;
            done_latch <= 1'b0;
            win        <= '0;
            wr_data    <= '0;
            pix_count  <= '0;
            inc_raddr  <= 1'b0;
            inc_waddr  <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            calc_start <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            error      <= 1'b0;
        end else begin
            inc_raddr  <= 1'b0;
            inc_waddr  <= 1'b0;
            calc_start <= 1'b0;
            frame_done <= 1'b0;
            wait_cnt   <= '0;
            if (active_c && bus.i_stop) begin
                state  <= S_IDLE;
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
                busy   <= 1'b0;
                idx    <= '0;
            end else if (waiting_c && !hit_c) begin
                if (timeout_c) begin
                    state  <= S_ERR;
                    error  <= 1'b1;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (bus.i_start) begin
                            state      <= S_REQ_R;
                            inc_raddr  <= 1'b1;
                            busy       <= 1'b1;
                            error      <= 1'b0;
                            pix_count  <= '0;
                            done_latch <= 1'b0;
                            idx        <= '0;
                        end
                    end
                    S_REQ_R: state <= S_WAIT_R;
                    S_WAIT_R: begin
                        state  <= S_RD;
                        mem_rd <= 1'b1;
                    end
                    S_RD: begin
                        win[idx] <= bus.i_rd_data;
                        mem_rd   <= 1'b0;
                        if (idx == IDX_W'(WIN_PIX - 1)) begin
                            state      <= S_CALC;
                            calc_start <= 1'b1;
                        end else begin
                            idx       <= idx + 1'b1;
                            state     <= S_REQ_R;
                            inc_raddr <= 1'b1;
                        end
                    end
                    S_CALC: begin
                        wr_data   <= bus.i_result;
                        state     <= S_REQ_W;
                        inc_waddr <= 1'b1;
                    end
                    S_REQ_W: state <= S_WAIT_W;
                    S_WAIT_W: begin
                        done_latch <= bus.i_done;
                        state      <= S_WR;
                        mem_wr     <= 1'b1;
                    end
                    S_WR: begin
                        mem_wr    <= 1'b0;
                        pix_count <= pix_count + 32'd1;
                        idx       <= '0;
                        if (done_latch) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state     <= S_REQ_R;
                            inc_raddr <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Drive the bundle from the output registers
    assign bus.o_inc_raddr  = inc_raddr;
    assign bus.o_inc_waddr  = inc_waddr;
    assign bus.o_mem_rd     = mem_rd;
    assign bus.o_mem_wr     = mem_wr;
    assign bus.o_wr_data    = wr_data;
    assign bus.o_win_data   = win;
    assign bus.o_calc_start = calc_start;
    assign bus.o_busy       = busy;
    assign bus.o_frame_done = frame_done;
    assign bus.o_error      = error;
    assign bus.o_pix_count  = pix_count;
endmodule

// File: doc/edge_window_sequencer.md
Name: edge_window_sequencer

Overview:
- Top-level per-pixel sequencer for the edge-detection datapath.
- Steps the address counter one address at a time: requests each read address, fetches the 3x3 window from memory, then launches the kernel.
- Then requests a write address and stores the result, repeating until the address counter flags the last output pixel.
- Sits between the host start/stop control, the address counter, the memory port and the kernel compute block.

Parameters:
DATA_W, 8, pixel width in bits
WIN_PIX, 9, pixels per window (3x3)
TIMEOUT, 1023, max cycles spent waiting on any single handshake before error

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
i_start  in  1  start frame; sampled in IDLE/DONE/ERR only
i_stop  in  1  synchronous abort
o_inc_raddr  out  1  one-cycle pulse to address counter: advance read address
i_r_ready  in  1  address counter: read address valid (one-cycle pulse)
o_inc_waddr  out  1  one-cycle pulse: advance write address
i_w_ready  in  1  address counter: write address valid (one-cycle pulse)
i_done  in  1  address counter: last write address (coincident with i_w_ready)
o_mem_rd  out  1  memory read request, level
i_rd_valid  in  1  read data valid
i_rd_data  in  DATA_W  read data
o_mem_wr  out  1  memory write request, level
i_wr_ack  in  1  write accepted
o_wr_data  out  DATA_W  write data
o_win_data  out  WIN_PIX*DATA_W  window; slot k at bits [k*DATA_W +: DATA_W]
o_calc_start  out  1  one-cycle pulse to kernel
i_calc_done  in  1  kernel result valid
i_result  in  DATA_W  kernel result
o_busy  out  1  high in every state except IDLE, DONE, ERR
o_frame_done  out  1  one-cycle pulse at frame end
o_error  out  1  sticky handshake-timeout flag
o_pix_count  out  32  output pixels written this frame

Behaviour:
- Reset (n_rst low at a clk edge):
  - state IDLE.
  - All outputs 0: o_win_data, o_wr_data, o_pix_count, o_error all zero.
  - Slot index 0; done latch 0; wait counter 0.
- States and transitions:
  - IDLE: i_start -> REQ_R. On this transition clear o_pix_count and the done latch.
  - REQ_R: o_inc_raddr=1 for exactly one cycle -> WAIT_R.
  - WAIT_R: i_r_ready -> RD.
  - RD: o_mem_rd=1. On i_rd_valid, capture i_rd_data into slot idx. If idx==WIN_PIX-1 -> CALC, else idx+=1 and -> REQ_R.
  - CALC: o_calc_start=1 for its first cycle only, then wait. On i_calc_done, latch i_result into o_wr_data and -> REQ_W.
  - REQ_W: o_inc_waddr=1 for one cycle -> WAIT_W.
  - WAIT_W: on i_w_ready, set done latch = i_done and -> WR.
  - WR: o_mem_wr=1. On i_wr_ack, o_pix_count+=1 and idx=0. Then -> DONE if done latch set, else -> REQ_R.
  - DONE: o_frame_done=1 for its first cycle. i_start -> REQ_R, clearing the count exactly as from IDLE.
  - ERR: o_error=1; all request outputs 0. i_start clears o_error and -> REQ_R, clearing the count.
- Handshake timing:
  - A pulse on i_r_ready/i_w_ready in the same cycle as the inc pulse is ignored. Only WAIT_R/WAIT_W sample them.
  - A response arriving in the same cycle as entry to RD/WR/CALC is accepted. Minimum read step: REQ_R, WAIT_R, RD = 3 cycles.
- Timeout:
  - Wait counter is cleared on every state change.
  - It increments each cycle spent in WAIT_R, RD, CALC, WAIT_W or WR.
  - When it reaches TIMEOUT without the awaited event -> ERR. Requests drop in that same transition.
- Data stability:
  - o_win_data holds between captures.
  - o_wr_data holds from latch until the next result.
- Abort:
  - i_stop while busy -> IDLE at the next edge. All strobes low, idx 0.
  - o_pix_count is preserved; o_error is unchanged.
  - i_stop has priority over every transition, including a simultaneous i_start or handshake.
  - i_stop in IDLE/DONE/ERR is ignored.
- Overflow: o_pix_count wraps modulo 2^32, with no flag.

Test Plan:
1. Reset, then i_start with memory/kernel responding after 1 cycle and i_done on the 2nd write -> 18 inc_raddr pulses, 2 inc_waddr pulses, o_pix_count=2, one o_frame_done pulse, o_busy low after.
2. Read data 0x10..0x18 for one window -> o_win_data slot0=0x10 … slot8=0x18 at CALC. i_result=0xA5 -> o_wr_data=0xA5 while o_mem_wr is high.
3. i_rd_valid withheld for TIMEOUT cycles (param 15) in RD -> ERR after exactly 15 waiting cycles, o_error=1, o_mem_rd=0. i_start clears o_error and o_pix_count=0.
4. i_stop asserted in WR together with i_wr_ack -> IDLE next cycle, no count increment, o_mem_wr=0.
5. i_r_ready pulsed in the same cycle as o_inc_raddr, then again 2 cycles later -> only the second is taken; RD entered one cycle after it.
6. n_rst low for one edge mid-CALC -> all outputs 0 next cycle. A late i_calc_done has no effect.
